hvac_actuator_seq: RTL
======================

Name: hvac_actuator_seq

Overview:
- Downstream stage of the thermostat controller. Consumes its `heating`/`cooling` demand bits and drives the physical heater and cooler enables.
- Enforces minimum on-time and minimum rest time per actuation, and never drives both actuators at once.
- Flags illegal demand (both requested) and honours a master enable for safety shutdown.
- Sits between the thermostat core and the board-level actuator pins, in the same clock domain.

Parameters:
- MIN_ON_CYCLES, 8, minimum cycles an actuator stays on once started (≥1)
- MIN_OFF_CYCLES, 8, cycles both actuators are held off after any actuation ends (≥1)
- CNT_W, 8, dwell counter width; must satisfy 2^CNT_W > max(MIN_ON_CYCLES, MIN_OFF_CYCLES)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  master enable; low forces outputs off
- heat_req  input  1  heating demand from thermostat core
- cool_req  input  1  cooling demand from thermostat core
- fault_clr  input  1  synchronous clear of sticky fault
- heater_on  output  1  heater drive, registered
- cooler_on  output  1  cooler drive, registered
- busy  output  1  high in HEAT, COOL or REST
- fault  output  1  sticky: both requests seen high on the same edge
- state  output  2  current FSM state (IDLE=0, HEAT=1, COOL=2, REST=3)

Behaviour:
- Reset is asynchronous and active-low; rst_n=0 forces:
  - state=IDLE, heater_on=0, cooler_on=0, busy=0, fault=0, dwell counter=0.
- Reset mid-operation drops the active actuator immediately, with no REST period.
- Outputs decode from the registered state: heater_on=(state==HEAT), cooler_on=(state==COOL), busy=(state!=IDLE). Glitch-free.
- Latency: a request sampled at edge N in IDLE gives actuator high from edge N (visible in cycle N+1).
- Dwell counter: reset to 0 on each state entry. Increments every cycle in HEAT/COOL/REST and saturates at max(MIN_ON_CYCLES, MIN_OFF_CYCLES)-1.
- IDLE transitions:
  - enable & heat_req & !cool_req -> HEAT.
  - enable & cool_req & !heat_req -> COOL.
  - Otherwise stay in IDLE.
- HEAT:
  - exit condition X = !heat_req | cool_req.
  - X & cnt==MIN_ON_CYCLES-1 (or saturated beyond) -> REST.
  - !enable -> REST immediately, overriding min-on.
  - Result: heater high for ≥MIN_ON_CYCLES cycles unless enable drops.
- COOL: symmetric to HEAT, with cool_req and heat_req swapped.
- REST: both actuators off; goes to IDLE when cnt==MIN_OFF_CYCLES-1. REST therefore lasts exactly MIN_OFF_CYCLES cycles.
- Minimum off gap between any two actuations is MIN_OFF_CYCLES+1 cycles, because one IDLE cycle is mandatory.
- HEAT->COOL and COOL->HEAT are never direct; both always pass through REST and IDLE.
- enable low in REST: REST still completes, then the block holds IDLE.
- Fault handling:
  - fault sets on any edge with heat_req&cool_req, in any state.
  - fault_clr clears it; if set and clear occur on the same edge, set wins.
  - fault does not alter FSM flow beyond the X condition above.
- Requests are assumed synchronous to clk; no internal synchronisers.

Decomposition:
- Shared package hvac_pkg holds:
  - state typedef (IDLE/HEAT/COOL/REST, 2 bits)
  - default MIN_ON/MIN_OFF constants
  - CNT_W
- One sub-module: dwell_timer, a loadable saturating up-counter with clear-on-entry, a terminal-compare input and a `done` output. It is instantiated once and shared by all timed states.

Test Plan:
- Reset/idle: rst_n=0 for 3 cycles with heat_req=1 -> all outputs 0. Release rst_n, enable=1 -> heater_on=1 on the first edge; state=1, busy=1.
- Min on-time: heat_req pulsed high for 2 cycles -> heater_on high exactly 8 cycles, then REST for 8 cycles with both low, then state=0.
- Changeover: heat_req=1 for 20 cycles, then cool_req=1, heat_req=0 -> heater drops at cycle 20. Both low for 9 cycles (8 REST + 1 IDLE), then cooler_on=1; never heater_on&cooler_on.
- Conflict: in COOL, heat_req=cool_req=1 for 1 cycle at cnt=3 -> fault=1 sticky; cooler stays on until cnt=7, then REST. fault_clr=1 -> fault=0 next edge.
- Safety: in HEAT at cnt=2, enable=0 -> heater_on=0 next cycle and REST for 8 cycles. With enable held low, state stays 0 even with heat_req=1.
- Async reset mid-REST: rst_n low between edges at REST cnt=4 -> state=0 immediately, without waiting for an edge. After release with cool_req=1, cooler_on=1 on the first edge (no residual rest).

Source files
------------

// File: rtl/hvac_pkg.sv
// Shared types and defaults for the HVAC actuator sequencer.
// State encoding is visible on the block's debug/state output.
package hvac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAT = 2'd1,
        COOL = 2'd2,
        REST = 2'd3
    } hvac_state_t;

    localparam int DEF_MIN_ON_CYCLES  = 8;
    localparam int DEF_MIN_OFF_CYCLES = 8;
    localparam int DEF_CNT_W          = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Saturating up-counter shared by all timed states; cleared on every state
// entry, with done raised once the count reaches the supplied terminal value.
module dwell_timer #(
    parameter int CNT_W   = 8,
    parameter int SAT_VAL = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             count_en,
    input  logic [CNT_W-1:0] terminal,
    output logic             done
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(SAT_VAL);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en && (cnt != SAT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // ">=" so a count saturated past the terminal still reports done.
    assign done = (cnt >= terminal);

endmodule

// File: rtl/hvac_actuator_seq.sv
// Heater/cooler sequencer: enforces minimum on-time, a fixed rest period
// after each actuation, mutual exclusion, sticky conflict fault and master enable.
module hvac_actuator_seq
    import hvac_pkg::*;
#(
    parameter int MIN_ON_CYCLES  = DEF_MIN_ON_CYCLES,
    parameter int MIN_OFF_CYCLES = DEF_MIN_OFF_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       heat_req,
    input  logic       cool_req,
    input  logic       fault_clr,
    output logic       heater_on,
    output logic       cooler_on,
    output logic       busy,
    output logic       fault,
    output logic [1:0] state
);

    localparam int               SAT_VAL  = max2(MIN_ON_CYCLES, MIN_OFF_CYCLES) - 1;
    localparam logic [CNT_W-1:0] ON_TERM  = CNT_W'(MIN_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_TERM = CNT_W'(MIN_OFF_CYCLES - 1);

    hvac_state_t      state_q, state_d;
    logic             dwell_done;
    logic             dwell_clear;
    logic [CNT_W-1:0] dwell_term;

    dwell_timer #(
        .CNT_W  (CNT_W),
        .SAT_VAL(SAT_VAL)
    ) u_dwell (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (dwell_clear),
        .count_en(state_q != IDLE),
        .terminal(dwell_term),
        .done    (dwell_done)
    );

    always_comb begin
        state_d    = state_q;
        dwell_term = (state_q == REST) ? OFF_TERM : ON_TERM;
        case (state_q)
            IDLE: begin
                if (enable && heat_req && !cool_req) begin
                    state_d = HEAT;
                end else if (enable && cool_req && !heat_req) begin
                    state_d = COOL;
                end
            end
            HEAT: begin
                if (!enable || ((!heat_req || cool_req) && dwell_done)) begin
                    state_d = REST;
                end
            end
            COOL: begin
                if (!enable || ((!cool_req || heat_req) && dwell_done)) begin
                    state_d = REST;
                end
            end
            REST: begin
                if (dwell_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        dwell_clear = (state_d != state_q);
    end

    // Drives are registered from the next state so the pins never glitch
    // through intermediate state decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            heater_on <= 1'b0;
            cooler_on <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            heater_on <= (state_d == HEAT);
            cooler_on <= (state_d == COOL);
            busy      <= (state_d != IDLE);
        end
    end

    // Set has priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault <= 1'b0;
        end else if (heat_req && cool_req) begin
            fault <= 1'b1;
        end else if (fault_clr) begin
            fault <= 1'b0;
        end
    end

    assign state = state_q;

endmodule
